arbitro_somador: RTL

- Round-robin arbiter and sequencer that shares one mux-plus-adder datapath between NREQ requesters.
- Each requester submits operands A, B, C and select S. The block returns RES = A + (S ? B : C), truncated to WIDTH bits.
- Sits between the requesting units and a single shared 2:1 mux / adder pair. Sharing gives one adder instead of one per requester.
- Result is registered and returned with a valid/ready handshake, tagged with the requester id.

---
 rtl/arbitro_somador.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/arbitro_somador.sv
// arbitro_somador: round-robin arbiter in front of one shared mux + adder.
// Each requester offers operands A, B, C and a select S. The block grants one
// requester at a time and returns RES = A + (S ? B : C) mod 2^WIDTH, tagged
// with the id of the requester that owns it, over a valid/ready handshake.
//
// Sequence per transaction: IDLE (grant + operand capture) -> CALC (add) ->
// RESP (hold result until the consumer accepts it).
//
// Optional build macro SOMADOR_CARRY_EN: adds output resp_carry with the
// adder carry-out, registered together with resp_data.

module arbitro_somador #(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_c,
  input  logic [NREQ-1:0]       req_s,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data
`ifdef SOMADOR_CARRY_EN
  ,
  output logic                  resp_carry
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             any_valid;
  logic [IDW-1:0]   cap_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_m;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_m;
  logic             take;

  // Round-robin search: first valid requester after the last one served
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_valid && req_valid[(int'(last_grant) + k) % NREQ]) begin
        any_valid = 1'b1;
        winner    = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  // The shared 2:1 mux picks B or C of the winning requester at grant time
  always_comb begin
    sel_a = req_a[int'(winner)*WIDTH +: WIDTH];
    sel_m = req_s[winner] ? req_b[int'(winner)*WIDTH +: WIDTH]
                          : req_c[int'(winner)*WIDTH +: WIDTH];
  end

  assign take = (state == IDLE) && any_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the one-hot request accept (gated while in reset)
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[winner] = rst_n;
          state_next        = CALC;
        end
      end
      CALC: begin
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture at the request handshake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_m   <= '0;
      cap_id <= '0;
    end else if (take) begin
      op_a   <= sel_a;
      op_m   <= sel_m;
      cap_id <= winner;
    end
  end

`ifdef SOMADOR_CARRY_EN
  logic [WIDTH:0] sum_full;
  assign sum_full = {1'b0, op_a} + {1'b0, op_m};

  // Carry-out registered alongside the result, held until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_carry <= 1'b0;
    end else if (state == CALC) begin
      resp_carry <= sum_full[WIDTH];
    end
  end

  logic [WIDTH-1:0] sum_data;
  assign sum_data = sum_full[WIDTH-1:0];
`else
  logic [WIDTH-1:0] sum_data;
  assign sum_data = op_a + op_m;
`endif

  // Result register, response handshake and round-robin pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (state == CALC) begin
        resp_data  <= sum_data;
        resp_id    <= cap_id;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        last_grant <= resp_id;
      end
    end
  end

endmodule
